// File: rtl/serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_receiver
// Purpose  : Synchronises a shift/latch/data serial link and publishes frames.
// Revision : 1.0
// ============================================================================
module serial_frame_receiver #(
  parameter int WIDTH       = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             shift_pulse,
  input  logic             latch_clk,
  input  logic             sdata,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             locked,
  output logic [15:0]      frame_cnt
);

  localparam int             CW         = $clog2(WIDTH + 2);
  localparam logic [CW-1:0]  c_FULL_CNT = CW'(WIDTH);
  localparam logic [CW-1:0]  c_SAT_CNT  = CW'(WIDTH + 1);
  localparam logic [CW-1:0]  c_ONE      = CW'(1);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_shift_sync;
  logic [SYNC_STAGES-1:0] r_latch_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_shift_prev;
  logic                   r_latch_prev;
  logic                   r_data_prev;
  logic                   r_shift_det;
  logic                   r_latch_det;
  logic [WIDTH-1:0]       r_shreg;
  logic [CW-1:0]          r_bit_cnt;
  logic [WIDTH-1:0]       r_data_out;
  logic                   r_data_valid;
  logic                   r_frame_err;
  logic [15:0]            r_frame_cnt;

  logic [WIDTH-1:0]       w_shreg_nxt;
  logic [CW-1:0]          w_cnt_shifted;
  logic [CW-1:0]          w_bit_cnt_nxt;
  logic                   w_accept;
  logic                   w_reject;
  logic                   w_shift_edge;
  logic                   w_latch_edge;

  assign w_shift_edge = r_shift_sync[SYNC_STAGES-1] & ~r_shift_prev;
  assign w_latch_edge = r_latch_sync[SYNC_STAGES-1] & ~r_latch_prev;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shift is applied before the latch decision when both land in one cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_reject      = 1'b0;
    w_shreg_nxt   = r_shreg;
    w_cnt_shifted = r_bit_cnt;
    if (r_shift_det) begin
      w_shreg_nxt = {r_data_prev, r_shreg[WIDTH-1:1]};
      if (r_bit_cnt != c_SAT_CNT) begin
        w_cnt_shifted = r_bit_cnt + c_ONE;
      end
    end
    w_bit_cnt_nxt = w_cnt_shifted;
    if (r_latch_det) begin
      w_bit_cnt_nxt = '0;
      w_state_nxt   = RECV;
      if (r_state == RECV) begin
        if (w_cnt_shifted == c_FULL_CNT) begin
          w_accept = 1'b1;
        end else begin
          w_reject = 1'b1;
        end
      end
    end
  end

  // Edge pulses are registered once; r_data_prev keeps sdata aligned with them.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_shift_sync <= '0;
      r_latch_sync <= '0;
      r_data_sync  <= '0;
      r_shift_prev <= 1'b0;
      r_latch_prev <= 1'b0;
      r_data_prev  <= 1'b0;
      r_shift_det  <= 1'b0;
      r_latch_det  <= 1'b0;
      r_shreg      <= '0;
      r_bit_cnt    <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_shift_sync <= {r_shift_sync[SYNC_STAGES-2:0], shift_pulse};
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], latch_clk};
      r_data_sync  <= {r_data_sync[SYNC_STAGES-2:0], sdata};
      r_shift_prev <= r_shift_sync[SYNC_STAGES-1];
      r_latch_prev <= r_latch_sync[SYNC_STAGES-1];
      r_data_prev  <= r_data_sync[SYNC_STAGES-1];
      r_shift_det  <= w_shift_edge;
      r_latch_det  <= w_latch_edge;
      r_shreg      <= w_shreg_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_data_valid <= w_accept;
      r_frame_err  <= w_reject;
      if (w_accept) begin
        r_data_out  <= w_shreg_nxt;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign frame_cnt  = r_frame_cnt;
  assign locked     = (r_state == RECV);

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_receiver
// Purpose  : Randomised self-checking bench with a frame-level reference model.
// Revision : 1.0
// ============================================================================
module tb_serial_frame_receiver;

  localparam int WIDTH = 40;
  localparam int PHASE = 21;

  logic             sys_clk = 1'b0;
  logic             rst;
  logic             shift_pulse;
  logic             latch_clk;
  logic             sdata;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic             locked;
  logic [15:0]      frame_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: bits sent since the last latch, alignment flag, outputs.
  bit               q[$];
  bit               locked_m;
  logic [WIDTH-1:0] data_m;
  logic [15:0]      cnt_m;

  int               mon_dv;
  int               mon_err;
  logic [WIDTH-1:0] last_out;

  serial_frame_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .shift_pulse(shift_pulse),
    .latch_clk  (latch_clk),
    .sdata      (sdata),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .locked     (locked),
    .frame_cnt  (frame_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (rst) begin
      last_out = '0;
    end else begin
      if (data_valid) mon_dv++;
      if (frame_err) mon_err++;
      if (data_valid && frame_err) begin
        checks++;
        failures++;
        $display("FAIL pulse_overlap: data_valid and frame_err both high at %0t", $time);
      end
      if (data_out !== last_out) begin
        checks++;
        if (data_valid !== 1'b1) begin
          failures++;
          $display("FAIL data_out_change: data_out=%h changed without data_valid (was %h)", data_out, last_out);
        end
      end
      last_out = data_out;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    locked_m = 1'b0;
    data_m   = '0;
    cnt_m    = '0;
  endtask

  task automatic model_latch(output int ed, output int ee);
    ed = 0;
    ee = 0;
    if (!locked_m) begin
      locked_m = 1'b1;
    end else if (q.size() == WIDTH) begin
      for (int i = 0; i < WIDTH; i++) data_m[i] = q[i];
      cnt_m = cnt_m + 16'd1;
      ed = 1;
    end else begin
      ee = 1;
    end
    q.delete();
  endtask

  task automatic send_bit(input bit b);
    shift_pulse = 1'b0;
    sdata       = b;
    wait_cyc(PHASE);
    shift_pulse = 1'b1;
    wait_cyc(PHASE);
    q.push_back(b);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < WIDTH) send_bit(f[i]);
      else send_bit(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic check_outputs(input string name);
    checks++;
    if (data_out !== data_m) begin
      failures++;
      $display("FAIL %s data_out: got %h expected %h", name, data_out, data_m);
    end
    checks++;
    if (frame_cnt !== cnt_m) begin
      failures++;
      $display("FAIL %s frame_cnt: got %0d expected %0d", name, frame_cnt, cnt_m);
    end
    checks++;
    if (locked !== locked_m) begin
      failures++;
      $display("FAIL %s locked: got %b expected %b", name, locked, locked_m);
    end
  endtask

  task automatic do_latch(input string name);
    int ed;
    int ee;
    mon_dv      = 0;
    mon_err     = 0;
    shift_pulse = 1'b0;
    latch_clk   = 1'b1;
    wait_cyc(PHASE);
    latch_clk   = 1'b0;
    wait_cyc(PHASE);
    model_latch(ed, ee);
    checks++;
    if (mon_dv !== ed) begin
      failures++;
      $display("FAIL %s data_valid_cycles: got %0d expected %0d", name, mon_dv, ed);
    end
    checks++;
    if (mon_err !== ee) begin
      failures++;
      $display("FAIL %s frame_err_cycles: got %0d expected %0d", name, mon_err, ee);
    end
    check_outputs(name);
  endtask

  function automatic logic [WIDTH-1:0] rand_frame();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[WIDTH-1:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1; shift_pulse = 1'b0; latch_clk = 1'b0; sdata = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({data_out, data_valid, frame_err, locked, frame_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got dout=%h dv=%b err=%b lk=%b cnt=%0d expected all 0",
               data_out, data_valid, frame_err, locked, frame_cnt);
    end
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
    check_outputs("reset_release");
  endtask

  task automatic test_align_good();
    do_latch("align_dummy");
    send_frame(40'hA5_5A_F0_0F_C3, WIDTH);
    do_latch("align_good");
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] frames [4];
    frames[0] = 40'h00_0000_0000;
    frames[1] = 40'hFF_FFFF_FFFF;
    frames[2] = 40'h55_5555_5555;
    frames[3] = 40'hAA_AAAA_AAAA;
    for (int i = 0; i < 4; i++) begin
      send_frame(frames[i], WIDTH);
      do_latch($sformatf("b2b_%0d", i));
    end
  endtask

  task automatic test_short_long();
    send_frame(rand_frame(), WIDTH - 1);
    do_latch("short_39");
    send_frame(rand_frame(), WIDTH + 1);
    do_latch("long_41");
    send_frame(rand_frame(), WIDTH);
    do_latch("after_err_good");
  endtask

  task automatic test_reset_midstream();
    send_frame(rand_frame(), 10);
    shift_pulse = 1'b1;
    sdata       = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({data_out, data_valid, frame_err, locked, frame_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_async: got dout=%h dv=%b err=%b lk=%b cnt=%0d expected all 0",
               data_out, data_valid, frame_err, locked, frame_cnt);
    end
    wait_cyc(4);
    shift_pulse = 1'b0;
    rst = 1'b0;
    wait_cyc(PHASE);
    check_outputs("reset_mid_release");
  endtask

  task automatic test_hunt();
    send_frame(rand_frame(), 17);
    do_latch("hunt_17");
    send_frame(rand_frame(), WIDTH);
    do_latch("hunt_next_good");
  endtask

  task automatic test_latency();
    int ed;
    int ee;
    logic exp_dv;
    send_frame(rand_frame(), WIDTH);
    shift_pulse = 1'b0;
    @(negedge sys_clk);
    latch_clk = 1'b1;
    model_latch(ed, ee);
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      exp_dv = (k == 3);
      checks++;
      if (data_valid !== exp_dv) begin
        failures++;
        $display("FAIL latency_dv_t%0d: got %b expected %b", k, data_valid, exp_dv);
      end
    end
    wait_cyc(PHASE);
    latch_clk = 1'b0;
    wait_cyc(PHASE);
    check_outputs("latency");
  endtask

  task automatic test_wrap();
    @(negedge sys_clk);
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge sys_clk);
    release dut.r_frame_cnt;
    cnt_m = 16'hFFFF;
    send_frame(rand_frame(), WIDTH);
    do_latch("wrap");
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 6; i++) begin
      n = ($urandom_range(0, 2) == 0) ? 38 + int'($urandom_range(0, 4)) : WIDTH;
      send_frame(rand_frame(), n);
      do_latch($sformatf("random_%0d_len%0d", i, n));
    end
  endtask

  initial begin
    test_reset();
    test_align_good();
    test_back_to_back();
    test_short_long();
    test_reset_midstream();
    test_hunt();
    test_latency();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Receiving end of the three-wire shift/latch serial link driven by the 40-bit LED shifter (shift_pulse, latch_clk, sdata). It synchronises the three wires into sys_clk and deserialises sdata on each shift_pulse rising edge. On each latch_clk rising edge it publishes a frame word and checks its bit count. It acts as a loopback checker for the display chain and as the input side of an inter-board link carrying 40-bit Enigma lamp/key words.

## Interface
- WIDTH, 40: bits per frame; the transmitter sends bit 0 first.
- SYNC_STAGES, 2: flip-flop stages per input synchroniser; legal values are 2 or more.
- sys_clk  in  1  single system clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- shift_pulse  in  1  serial shift clock, asynchronous to sys_clk.
- latch_clk  in  1  frame latch strobe, asynchronous to sys_clk.
- sdata  in  1  serial data; stable around the rising edge of shift_pulse.
- data_out  out  WIDTH  last published frame; holds its value between frames.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- frame_err  out  1  one-cycle pulse on a latch whose bit count is not WIDTH.
- locked  out  1  high in state RECV.
- frame_cnt  out  16  count of good frames; wraps from 16'hFFFF to 0.

## Operation
- Each input passes through its own SYNC_STAGES-deep synchroniser. One additional register per signal holds the previous synchronised value. All three inputs have identical delay, so sdata stays aligned with shift_pulse.
- A shift edge is a synchronised shift_pulse going 0 to 1. A latch edge is a synchronised latch_clk going 0 to 1.
- On a shift edge:
  - the shift register loads {sdata_sync, shreg[WIDTH-1:1]}, so the first bit sent ends in bit 0 after WIDTH shifts;
  - bit_cnt increments and saturates at WIDTH+1;
  - bits beyond WIDTH keep shifting, and the oldest bits fall out of shreg[0].
- State machine, reset state HUNT:
  - HUNT: shifting and counting run normally. A latch edge clears bit_cnt and moves to RECV. No data_valid and no frame_err are produced in HUNT, because frame alignment is unknown.
  - RECV, latch edge with bit_cnt == WIDTH: data_out <= shreg, data_valid pulses, frame_cnt increments, bit_cnt clears.
  - RECV, latch edge with bit_cnt != WIDTH (short, or saturated at WIDTH+1): frame_err pulses, data_out and frame_cnt hold, bit_cnt clears, state stays RECV.
- If a shift edge and a latch edge are detected in the same cycle, the shift is applied first. The latch then evaluates the updated shreg and the incremented bit_cnt.
- A latch edge with no preceding shifts in RECV is a frame_err, because bit_cnt is 0.
- The transmitter's pattern of shift_pulse falling while sdata changes is tolerated, because sdata is sampled only on shift edges.
- Width rules:
  - bit_cnt is $clog2(WIDTH+2) bits wide;
  - frame_cnt is a 16-bit modulo counter;
  - no other arithmetic is performed.

## Timing
- Reset is asynchronous. While rst is high:
  - data_out = 0, data_valid = 0, frame_err = 0, locked = 0, frame_cnt = 0;
  - shreg = 0, bit_cnt = 0, all synchroniser and previous-value flops = 0, state = HUNT.
- Reset mid-frame discards partial data. The next latch edge is absorbed by HUNT.
- Edge detection latency: an input change first sampled high at sys_clk edge t is detected at edge t+SYNC_STAGES. The resulting register update is visible after edge t+SYNC_STAGES+1.
- data_valid and frame_err are high for exactly one cycle. They never assert in the same cycle.
- data_out changes only in the cycle data_valid asserts.
- locked rises together with the first RECV-entering latch update and falls only on reset.
- Input constraints for reliable capture:
  - each input level, and each sdata setup before a shift edge, holds for at least SYNC_STAGES+2 sys_clk cycles;
  - the transmitter's 21-cycle phases satisfy this.
- Throughput: one frame per WIDTH shift edges plus one latch edge. There is no backpressure, and data_out is overwritten by the next good frame.

## Test plan
- Reset: assert rst mid-stream, with inputs toggling → all outputs 0 immediately, without waiting for a clock edge; locked = 0 after release.
- Alignment plus good frame: send one dummy latch, then 40'hA5_5A_F0_0F_C3 LSB-first with 21-cycle phases, then a latch → locked = 1, data_valid pulses once, data_out = 40'hA5_5A_F0_0F_C3, frame_cnt = 1.
- Back-to-back frames: transmit 40'h0, 40'hFF_FFFF_FFFF, 40'h55_5555_5555 and 40'hAA_AAAA_AAAA in sequence → four data_valid pulses, data_out matches each frame in order, frame_cnt = 4, no frame_err.
- Short and long frames in RECV: send 39 bits then latch → frame_err pulse, data_out unchanged. Send 41 bits then latch → frame_err pulse, frame_cnt unchanged. Then send a correct frame → data_valid pulse.
- HUNT suppression: after reset send 17 bits then latch → no data_valid, no frame_err, locked = 1. The next 40-bit frame is accepted.
- Latency and counter wrap:
  - latch_clk held high from edge t → data_valid high in cycle t+3 only, with SYNC_STAGES = 2;
  - with frame_cnt forced to 16'hFFFF, one good frame → frame_cnt = 0.
